// File: rtl/dmem_if.sv
// Data-memory bus adapter: aligns stores, extracts loads, detects faults and
// timeouts, and returns one mem_ready pulse per access.
module dmem_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_read_req,
  input  logic              mem_write_req,
  input  logic [2:0]        mem_size,
  input  logic              mem_signed,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_ready,
  output logic              mem_error,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ready,
  input  logic              bus_err
);

  localparam int unsigned LANES  = XLEN / 8;
  localparam int unsigned OFS_W  = $clog2(LANES);
  localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned TO_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [OFS_W-1:0] off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
  logic [XLEN-1:0]  rdata_d;
  logic             bus_valid_d, bus_we_d;
  logic [XLEN-1:0]  bus_addr_d, bus_wdata_d;
  logic [LANES-1:0] bus_wstrb_d;

  logic             req;
  logic             mis;
  logic             bad;
  logic [7:0]       strb8;
  logic [OFS_W-1:0] req_off;

  // Shift the addressed lane down and extend to the access size.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] raw,
                                              input logic [OFS_W-1:0] off,
                                              input logic [1:0]       size,
                                              input logic             sgn);
    logic [63:0] s;
    logic [63:0] e;
    s = 64'(raw >> {off, 3'b000});
    case (size)
      2'd0:    e = {{56{sgn & s[7]}},  s[7:0]};
      2'd1:    e = {{48{sgn & s[15]}}, s[15:0]};
      2'd2:    e = {{32{sgn & s[31]}}, s[31:0]};
      default: e = s;
    endcase
    return XLEN'(e);
  endfunction

  assign req     = mem_read_req | mem_write_req;
  assign req_off = mem_addr[OFS_W-1:0];

  // Request decode: misalignment, illegal size and conflicting direction.
  always_comb begin
    mis   = 1'b0;
    strb8 = 8'hFF;
    case (mem_size[1:0])
      2'd0: begin mis = 1'b0;             strb8 = 8'h01; end
      2'd1: begin mis = mem_addr[0];      strb8 = 8'h03; end
      2'd2: begin mis = |mem_addr[1:0];   strb8 = 8'h0F; end
      default: begin mis = |mem_addr[2:0]; strb8 = 8'hFF; end
    endcase
    bad = mis | mem_size[2] | (mem_read_req & mem_write_req) |
          ((mem_size[1:0] == 2'd3) && (XLEN < 64));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    off_d       = off_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    rdata_d     = '0;
    bus_valid_d = bus_valid;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    bus_wstrb_d = bus_wstrb;
    case (state_q)
      IDLE: begin
        if (req && !flush) begin
          off_d    = req_off;
          size_d   = mem_size[1:0];
          sgn_d    = mem_signed;
          bus_we_d = mem_write_req;
          cnt_d    = '0;
          if (bad) begin
            state_d = FAULT;
          end else begin
            state_d     = BUSY;
            bus_valid_d = 1'b1;
            bus_addr_d  = {mem_addr[XLEN-1:OFS_W], {OFS_W{1'b0}}};
            bus_wdata_d = mem_wdata << {req_off, 3'b000};
            bus_wstrb_d = LANES'(strb8) << req_off;
          end
        end
      end
      BUSY: begin
        drop_d = drop_q | flush;
        if (bus_ready) begin
          state_d     = RESP;
          bus_valid_d = 1'b0;
          ready_d     = ~drop_d;
          error_d     = bus_err & ~drop_d;
          if (!drop_d && !bus_we && !bus_err) begin
            rdata_d = extract(bus_rdata, off_q, size_q, sgn_q);
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LIM))) begin
          state_d     = RESP;
          bus_valid_d = 1'b0;
          ready_d     = ~drop_d;
          error_d     = ~drop_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FAULT: begin
        drop_d  = drop_q | flush;
        state_d = RESP;
        ready_d = ~drop_d;
        error_d = ~drop_d;
      end
      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      off_q     <= '0;
      size_q    <= 2'd0;
      sgn_q     <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      mem_rdata <= '0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      off_q     <= off_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      mem_rdata <= rdata_d;
      bus_valid <= bus_valid_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      bus_wstrb <= bus_wstrb_d;
    end
  end

  // A flush arriving in the response cycle itself still cancels the pulse.
  assign mem_ready = ready_q & ~flush;
  assign mem_error = error_q & ~flush;

endmodule

// File: tb/tb_dmem_if.sv
// Directed scoreboard bench for dmem_if (XLEN=64, TIMEOUT=4).
module tb_dmem_if;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [2:0]  mem_size;
  logic        mem_signed;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        mem_error;
  logic        bus_valid;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   hang = 0;
  int   delay = 0;
  int   wait_cnt = 0;

  dmem_if #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave: answers after 'delay' waiting cycles unless hung.
  initial bus_ready = 1'b0;
  always @(negedge clk) begin
    if (bus_valid && !hang) begin
      if (wait_cnt >= delay) bus_ready = 1'b1;
      else begin
        bus_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus_ready = 1'b0;
      wait_cnt  = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] load_model(input logic [63:0] raw, input int off,
                                             input int size, input bit sgn);
    logic [63:0] v;
    logic [63:0] m;
    int bits;
    bits = 8 << size;
    v = raw >> (8 * off);
    m = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    v = v & m;
    if (sgn && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  task automatic clear_req();
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [2:0] sz, input bit sg,
                       output int n);
    @(posedge clk); #1;
    mem_read_req  = rd;
    mem_write_req = wr;
    mem_addr      = addr;
    mem_wdata     = wd;
    mem_size      = sz;
    mem_signed    = sg;
    n = cyc;
  endtask

  task automatic wait_resp(input string tag);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) got = 1'b1;
    end
    check({tag, "_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_lat"}, 64'(cyc), 64'(e.due));
        check({tag, "_err"}, 64'(mem_error), 64'(e.err));
        check({tag, "_data"}, mem_rdata, e.rdata);
      end
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
    end
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    check({tag, "_pulse"}, 64'(mem_ready), 64'd0);
  endtask

  initial begin
    int          n;
    int          off;
    int          vcnt;
    int          rcnt;
    logic [2:0]  sz;
    bit          sg;
    logic [63:0] raw;
    logic [63:0] wd;

    resetn = 1'b0; flush = 1'b0; clear_req();
    mem_addr = '0; mem_wdata = '0; mem_size = '0; mem_signed = 1'b0;
    bus_rdata = '0; bus_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(bus_valid), 64'd0);
    check("rst_we", 64'(bus_we), 64'd0);
    check("rst_addr", bus_addr, 64'd0);
    check("rst_wdata", bus_wdata, 64'd0);
    check("rst_wstrb", 64'(bus_wstrb), 64'd0);
    check("rst_ready", 64'(mem_ready), 64'd0);
    check("rst_error", 64'(mem_error), 64'd0);
    check("rst_rdata", mem_rdata, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // LB signed from byte lane 3
    bus_rdata = 64'h0000_0000_80FF_0000;
    issue(1, 0, 64'h1003, 64'd0, 3'd0, 1, n);
    sb.push_back('{64'hFFFF_FFFF_FFFF_FF80, 1'b0, n + 2});
    @(negedge clk); @(negedge clk);
    check("lb_valid", 64'(bus_valid), 64'd1);
    check("lb_addr", bus_addr, 64'h1000);
    check("lb_we", 64'(bus_we), 64'd0);
    wait_resp("lb");

    // SH into the top halfword
    issue(0, 1, 64'h2006, 64'hBEEF, 3'd1, 0, n);
    sb.push_back('{64'd0, 1'b0, n + 2});
    @(negedge clk); @(negedge clk);
    check("sh_valid", 64'(bus_valid), 64'd1);
    check("sh_strb", 64'(bus_wstrb), 64'hC0);
    check("sh_wdata", bus_wdata, 64'hBEEF_0000_0000_0000);
    check("sh_we", 64'(bus_we), 64'd1);
    check("sh_addr", bus_addr, 64'h2000);
    wait_resp("sh");

    // Faulting requests: misaligned, read+write, illegal size
    issue(1, 0, 64'h3002, 64'd0, 3'd2, 0, n);
    sb.push_back('{64'd0, 1'b1, n + 2});
    @(negedge clk); @(negedge clk);
    check("mis_novalid", 64'(bus_valid), 64'd0);
    wait_resp("lw_mis");
    issue(1, 1, 64'h3000, 64'd0, 3'd2, 0, n);
    sb.push_back('{64'd0, 1'b1, n + 2});
    @(negedge clk); @(negedge clk);
    check("rw_novalid", 64'(bus_valid), 64'd0);
    wait_resp("rw_both");
    issue(1, 0, 64'h3000, 64'd0, 3'd5, 0, n);
    sb.push_back('{64'd0, 1'b1, n + 2});
    wait_resp("bad_size");

    // LD with a hung bus times out after 4 cycles
    hang = 1;
    issue(1, 0, 64'h6000, 64'd0, 3'd3, 0, n);
    sb.push_back('{64'd0, 1'b1, n + 5});
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("to_valid", 64'(bus_valid), 64'd1);
    end
    wait_resp("ld_timeout");
    hang = 0;

    // Bus error on a load
    bus_err = 1'b1;
    bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(1, 0, 64'h7002, 64'd0, 3'd1, 1, n);
    sb.push_back('{64'd0, 1'b1, n + 2});
    wait_resp("bus_err");
    bus_err = 1'b0;

    // Loads of every size and signedness at random aligned offsets
    for (int i = 0; i < 8; i++) begin
      sz  = 3'(i % 4);
      sg  = (i >= 4);
      off = int'(($urandom_range(0, 7) >> (i % 4)) << (i % 4));
      raw = {$urandom, $urandom};
      bus_rdata = raw;
      issue(1, 0, 64'h8000 + 64'(off), 64'd0, sz, sg, n);
      sb.push_back('{load_model(raw, off, i % 4, sg), 1'b0, n + 2});
      wait_resp($sformatf("load%0d", i));
    end

    // Stores of every size at random aligned offsets
    for (int i = 0; i < 4; i++) begin
      off = int'(($urandom_range(0, 7) >> i) << i);
      wd  = {$urandom, $urandom};
      issue(0, 1, 64'h9000 + 64'(off), wd, 3'(i), 0, n);
      sb.push_back('{64'd0, 1'b0, n + 2});
      @(negedge clk); @(negedge clk);
      check($sformatf("st%0d_strb", i), 64'(bus_wstrb), 64'(((1 << (1 << i)) - 1) << off));
      check($sformatf("st%0d_wdata", i), bus_wdata, wd << (8 * off));
      check($sformatf("st%0d_addr", i), bus_addr, 64'h9000);
      wait_resp($sformatf("st%0d", i));
    end

    // LWU with slow bus and a flush pulse while busy: no response
    delay = 3;
    bus_rdata = 64'h1234_5678_9ABC_DEF0;
    issue(1, 0, 64'h4004, 64'd0, 3'd2, 0, n);
    vcnt = 0; rcnt = 0;
    @(posedge clk); #1;
    flush = 1'b1;
    clear_req();
    @(negedge clk);
    if (bus_valid) vcnt++;
    if (mem_ready || mem_error) rcnt++;
    @(posedge clk); #1 flush = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus_valid) vcnt++;
      if (mem_ready || mem_error) rcnt++;
    end
    check("flush_bus_cycles", 64'(vcnt), 64'd4);
    check("flush_no_resp", 64'(rcnt), 64'd0);
    delay = 0;
    raw = 64'hDEAD_BEEF_8765_4321;
    bus_rdata = raw;
    issue(1, 0, 64'h4008, 64'd0, 3'd2, 0, n);
    sb.push_back('{load_model(raw, 0, 2, 0), 1'b0, n + 2});
    wait_resp("after_flush");

    // Flush in the response cycle suppresses the pulse
    bus_err = 1'b1;
    issue(1, 0, 64'hA000, 64'd0, 3'd0, 0, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    clear_req();
    @(negedge clk);
    check("resp_flush_ready", 64'(mem_ready), 64'd0);
    check("resp_flush_error", 64'(mem_error), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("resp_flush_after", 64'(mem_ready), 64'd0);
    bus_err = 1'b0;

    // Asynchronous reset while a store is on the bus
    hang = 1;
    issue(0, 1, 64'h5008, 64'h1122_3344_5566_7788, 3'd3, 0, n);
    @(posedge clk); #1;
    check("prerst_valid", 64'(bus_valid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_valid", 64'(bus_valid), 64'd0);
    check("arst_we", 64'(bus_we), 64'd0);
    check("arst_addr", bus_addr, 64'd0);
    check("arst_wdata", bus_wdata, 64'd0);
    check("arst_wstrb", 64'(bus_wstrb), 64'd0);
    check("arst_ready", 64'(mem_ready), 64'd0);
    clear_req();
    hang = 0;
    @(posedge clk); #1 resetn = 1'b1;
    raw = 64'h0102_0304_0506_07F8;
    bus_rdata = raw;
    issue(1, 0, 64'hB000, 64'd0, 3'd0, 1, n);
    sb.push_back('{64'hFFFF_FFFF_FFFF_FFF8, 1'b0, n + 2});
    wait_resp("post_reset");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
